// File: rtl/mac_block_param_pkg.sv
// Shared constants for the parametrised MAC slice: default widths and the
// precision mode encodings (limb count N = 2**mode).
package mac_block_param_pkg;

   localparam int MAC_MIN_W_DEF  = 8;
   localparam int MAC_LANES_DEF  = 4;
   localparam int MAC_ACC_W_DEF  = 48;
   localparam int MAC_MODE_W_DEF = 3;

   localparam int MAC_MODE_X1  = 0;
   localparam int MAC_MODE_X2  = 1;
   localparam int MAC_MODE_X4  = 2;
   localparam int MAC_MODE_X8  = 3;
   localparam int MAC_MODE_X16 = 4;

   // Number of A limbs selected by a mode value.
   function automatic int mac_limb_count(input int mode);
      return 1 << mode;
   endfunction

endpackage

// File: rtl/mac_block_param_if.sv
// Operand/control/result bundle between the array controller and one MAC column.
interface mac_block_param_if #(
   parameter int MIN_W  = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 48,
   parameter int MODE_W = 3
);
   // Handshake: an op is taken on a rising edge when en=1 and in_valid=1; there
   // is no ready, en is a global stall. out_valid marks a new c for one enabled
   // cycle and holds together with c/ovf while en=0.
   logic                   en;
   logic                   in_valid;
   logic [MODE_W-1:0]      mode;
   logic                   acc_en;
   logic                   start;
   logic [ACC_W-1:0]       init_val;
   logic [LANES*MIN_W-1:0] a;
   logic [MIN_W-1:0]       b;
   logic                   out_valid;
   logic [ACC_W-1:0]       c;
   logic                   ovf;

   modport master (
      output en, in_valid, mode, acc_en, start, init_val, a, b,
      input  out_valid, c, ovf
   );

   modport slave (
      input  en, in_valid, mode, acc_en, start, init_val, a, b,
      output out_valid, c, ovf
   );

endinterface

// File: rtl/mac_wide_mult.sv
// Combinational wide multiplier: top N lanes of A times one B word, built from
// per-lane products summed at MIN_W-limb offsets. Illegal modes give zero.
module mac_wide_mult
   import mac_block_param_pkg::*;
#(
   parameter int MIN_W  = 8,
   parameter int LANES  = 4,
   parameter int MODE_W = 3,
   localparam int PW    = (LANES + 1) * MIN_W
) (
   input  logic [LANES*MIN_W-1:0] a_i,
   input  logic [MIN_W-1:0]       b_i,
   input  logic [MODE_W-1:0]      mode_i,
   output logic [PW-1:0]          p_o
);

   localparam int LOG_L = $clog2(LANES);

   logic [2*MIN_W-1:0] lane_p [LANES];
   logic [PW-1:0]      term   [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_p[k] = {{MIN_W{1'b0}}, a_i[k*MIN_W +: MIN_W]} * {{MIN_W{1'b0}}, b_i};
   end

   // Lane k sits at limb k-(LANES-N); lanes below LANES-N are masked off.
   always_comb begin
      int n;
      n = 0;
      if (int'(mode_i) <= LOG_L) n = mac_limb_count(int'(mode_i));
      for (int k = 0; k < LANES; k++) begin
         term[k] = '0;
         if (n != 0 && k >= LANES - n)
            term[k] = PW'(lane_p[k]) << ((k - (LANES - n)) * MIN_W);
      end
   end

   always_comb begin
      p_o = '0;
      for (int k = 0; k < LANES; k++) p_o = p_o + term[k];
   end

endmodule

// File: rtl/mac_block_param.sv
// One MAC column: wide multiply in stage 1, pass-through or accumulate in
// stage 2, with global stall, per-op accumulator seed and sticky overflow.
module mac_block_param
   import mac_block_param_pkg::*;
#(
   parameter int MIN_W  = MAC_MIN_W_DEF,
   parameter int LANES  = MAC_LANES_DEF,
   parameter int ACC_W  = MAC_ACC_W_DEF,
   parameter int MODE_W = MAC_MODE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   mac_block_param_if.slave  bus
);

   localparam int PW = (LANES + 1) * MIN_W;

   logic [PW-1:0]    prod;
   logic [ACC_W-1:0] prod_fit;
   logic             trunc_d;

   mac_wide_mult #(
      .MIN_W  (MIN_W),
      .LANES  (LANES),
      .MODE_W (MODE_W)
   ) u_mult (
      .a_i    (bus.a),
      .b_i    (bus.b),
      .mode_i (bus.mode),
      .p_o    (prod)
   );

   if (PW > ACC_W) begin : g_trunc
      assign prod_fit = prod[ACC_W-1:0];
      assign trunc_d  = |prod[PW-1:ACC_W];
   end else begin : g_ext
      assign prod_fit = ACC_W'(prod);
      assign trunc_d  = 1'b0;
   end

   // Stage 1 registers
   logic             v1_q;
   logic [ACC_W-1:0] p1_q;
   logic             acc_en1_q;
   logic             start1_q;
   logic [ACC_W-1:0] init1_q;
   logic             trunc1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q      <= 1'b0;
         p1_q      <= '0;
         acc_en1_q <= 1'b0;
         start1_q  <= 1'b0;
         init1_q   <= '0;
         trunc1_q  <= 1'b0;
      end else if (bus.en) begin
         v1_q <= bus.in_valid;
         if (bus.in_valid) begin
            p1_q      <= prod_fit;
            acc_en1_q <= bus.acc_en;
            start1_q  <= bus.start;
            init1_q   <= bus.init_val;
            trunc1_q  <= trunc_d;
         end
      end
   end

   // Stage 2: accumulator, result and flag
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] c_q, c_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q;
   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   sum;

   // acc_q already holds the previous stage-2 result, so back-to-back
   // accumulation needs no forwarding path.
   assign base = start1_q ? init1_q : acc_q;
   assign sum  = {1'b0, base} + {1'b0, p1_q};

   always_comb begin
      acc_d = acc_q;
      c_d   = c_q;
      ovf_d = ovf_q;
      if (v1_q) begin
         if (acc_en1_q) begin
            acc_d = sum[ACC_W-1:0];
            c_d   = sum[ACC_W-1:0];
            ovf_d = (start1_q ? 1'b0 : ovf_q) | sum[ACC_W] | trunc1_q;
         end else begin
            c_d   = p1_q;
            ovf_d = ovf_q | trunc1_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         c_q         <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (bus.en) begin
         acc_q       <= acc_d;
         c_q         <= c_d;
         ovf_q       <= ovf_d;
         out_valid_q <= v1_q;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.c         = c_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_block_param.sv
// Directed bench for mac_block_param with hand-computed expectations checked by
// immediate assertions, one step per enabled clock edge.
module tb_mac_block_param;

   localparam int MIN_W  = 8;
   localparam int LANES  = 4;
   localparam int ACC_W  = 48;
   localparam int MODE_W = 3;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   mac_block_param_if #(
      .MIN_W(MIN_W), .LANES(LANES), .ACC_W(ACC_W), .MODE_W(MODE_W)
   ) bus ();

   mac_block_param #(
      .MIN_W(MIN_W), .LANES(LANES), .ACC_W(ACC_W), .MODE_W(MODE_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic drive(input logic v, input logic [2:0] m, input logic ae,
                        input logic st, input logic [47:0] iv,
                        input logic [31:0] av, input logic [7:0] bv);
      bus.in_valid = v;
      bus.mode     = m;
      bus.acc_en   = ae;
      bus.start    = st;
      bus.init_val = iv;
      bus.a        = av;
      bus.b        = bv;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 48'd0, 32'd0, 8'd0);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      bus.en = 1'b1;
      idle();
      cycle();
      cycle();
      chk("rst_out_valid", 48'(bus.out_valid), 48'd0);
      chk("rst_c", bus.c, 48'd0);
      chk("rst_ovf", 48'(bus.ovf), 48'd0);
      rst = 1'b0;
      cycle();

      // single-lane multiply, latency check
      drive(1'b1, 3'd0, 1'b0, 1'b0, 48'd0, 32'h1200_0000, 8'h10);
      cycle();
      idle();
      chk("lat_e1_valid", 48'(bus.out_valid), 48'd0);
      cycle();
      chk("lat_e2_valid", 48'(bus.out_valid), 48'd1);
      chk("lat_e2_c", bus.c, 48'h120);
      chk("lat_e2_ovf", 48'(bus.ovf), 48'd0);
      cycle();
      chk("lat_e3_valid", 48'(bus.out_valid), 48'd0);
      chk("lat_e3_c_hold", bus.c, 48'h120);

      // quad then dual precision, then an illegal mode
      drive(1'b1, 3'd2, 1'b0, 1'b0, 48'd0, 32'h0102_0304, 8'h02);
      cycle();
      drive(1'b1, 3'd1, 1'b0, 1'b0, 48'd0, 32'h0102_0304, 8'h03);
      cycle();
      chk("x4_c", bus.c, 48'h0204_0608);
      drive(1'b1, 3'd3, 1'b0, 1'b0, 48'd0, 32'hFFFF_FFFF, 8'hFF);
      cycle();
      chk("x2_c", bus.c, 48'h0306);
      chk("x2_valid", 48'(bus.out_valid), 48'd1);
      idle();
      cycle();
      chk("illegal_mode_c", bus.c, 48'd0);
      chk("illegal_mode_valid", 48'(bus.out_valid), 48'd1);

      // accumulate, multiply-only in between, continue
      drive(1'b1, 3'd0, 1'b1, 1'b1, 48'd100, 32'h0500_0000, 8'd3);
      cycle();
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0200_0000, 8'd7);
      cycle();
      chk("acc_start", bus.c, 48'd115);
      drive(1'b1, 3'd0, 1'b0, 1'b0, 48'd0, 32'h0100_0000, 8'd1);
      cycle();
      chk("acc_cont", bus.c, 48'd129);
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0100_0000, 8'd1);
      cycle();
      chk("acc_mulonly", bus.c, 48'd1);
      idle();
      cycle();
      chk("acc_resume", bus.c, 48'd130);
      cycle();
      chk("acc_drain_valid", 48'(bus.out_valid), 48'd0);

      // streaming accumulate 1+2+3+4+5 with a 3-cycle stall
      drive(1'b1, 3'd0, 1'b1, 1'b1, 48'd0, 32'h0100_0000, 8'd1);
      cycle();
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0200_0000, 8'd1);
      cycle();
      chk("stall_pre_c", bus.c, 48'd1);
      bus.en = 1'b0;
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0900_0000, 8'd1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_valid_hold", 48'(bus.out_valid), 48'd1);
         chk("stall_c_hold", bus.c, 48'd1);
      end
      bus.en = 1'b1;
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0300_0000, 8'd1);
      cycle();
      chk("stream_2", bus.c, 48'd3);
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0400_0000, 8'd1);
      cycle();
      chk("stream_3", bus.c, 48'd6);
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0500_0000, 8'd1);
      cycle();
      chk("stream_4", bus.c, 48'd10);
      idle();
      cycle();
      chk("stream_final", bus.c, 48'd15);
      chk("stream_final_valid", 48'(bus.out_valid), 48'd1);
      cycle();
      chk("stream_no_dup", 48'(bus.out_valid), 48'd0);

      // overflow: set by carry, kept by multiply-only, cleared by start
      drive(1'b1, 3'd0, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 32'h0100_0000, 8'd1);
      cycle();
      drive(1'b1, 3'd0, 1'b0, 1'b0, 48'd0, 32'h0300_0000, 8'd3);
      cycle();
      chk("ovf_wrap_c", bus.c, 48'd0);
      chk("ovf_set", 48'(bus.ovf), 48'd1);
      drive(1'b1, 3'd0, 1'b1, 1'b1, 48'd0, 32'h0200_0000, 8'd2);
      cycle();
      chk("ovf_mulonly_c", bus.c, 48'd9);
      chk("ovf_mulonly_keep", 48'(bus.ovf), 48'd1);
      idle();
      cycle();
      chk("ovf_start_c", bus.c, 48'd4);
      chk("ovf_start_clear", 48'(bus.ovf), 48'd0);

      // asynchronous reset with ops in flight
      drive(1'b1, 3'd0, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, 32'h0100_0000, 8'd1);
      cycle();
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0500_0000, 8'd1);
      cycle();
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0600_0000, 8'd1);
      cycle();
      chk("pre_rst_c", bus.c, 48'd5);
      chk("pre_rst_ovf", 48'(bus.ovf), 48'd1);
      idle();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 48'(bus.out_valid), 48'd0);
      chk("async_rst_c", bus.c, 48'd0);
      chk("async_rst_ovf", 48'(bus.ovf), 48'd0);
      #1 rst = 1'b0;
      cycle();
      chk("post_rst_drop1", 48'(bus.out_valid), 48'd0);
      cycle();
      chk("post_rst_drop2", 48'(bus.out_valid), 48'd0);
      drive(1'b1, 3'd0, 1'b1, 1'b0, 48'd0, 32'h0700_0000, 8'd1);
      cycle();
      idle();
      chk("post_rst_e1", 48'(bus.out_valid), 48'd0);
      cycle();
      chk("post_rst_e2_valid", 48'(bus.out_valid), 48'd1);
      chk("post_rst_acc_clear", bus.c, 48'd7);
      chk("post_rst_ovf", 48'(bus.ovf), 48'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mac_block_param.md
Name: mac_block_param

Overview:
Parametrised successor of the fixed 4-lane MAC slice. It multiplies a configurable-width concatenation of A lanes by one B word (single/dual/quad/...-precision), then either passes the product through or accumulates it. It is a 2-stage pipeline with valid tracking, a global stall, per-operation accumulator init and a sticky overflow flag. Instantiated per column in the MAC array; the array controller drives it.

Parameters:
MIN_W, 8, width of one A/B lane word
LANES, 4, number of A lanes; power of two, 1..16
ACC_W, 48, accumulator and output width; ACC_W >= 2*MIN_W
MODE_W, 3, width of mode field; 2**MODE_W > log2(LANES)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  pipeline enable; low = all stage registers hold (stall)
in_valid  in  1  operand/control bundle valid this cycle
mode  in  MODE_W  precision: limb count N = 2**mode
acc_en  in  1  1 = accumulate, 0 = multiply-only
start  in  1  with acc_en: reload accumulator from init_val before adding
init_val  in  ACC_W  accumulator seed
a  in  LANES*MIN_W  A lanes; lane k = a[k*MIN_W +: MIN_W]
b  in  MIN_W  B word
out_valid  out  1  c holds a new result
c  out  ACC_W  result
ovf  out  1  sticky overflow/truncation flag

Behaviour:
- Reset (async, any time): s1/s2 valids, accumulator, c, ovf all cleared to 0. In-flight ops are dropped. First accepted input after deassertion behaves as if the pipe were empty.
- An input is accepted on a rising clk edge when en=1 and in_valid=1. With en=0 nothing advances, nothing is accepted, and out_valid/c/ovf hold.
- Arithmetic, all unsigned:
  - Operand A = concat of top N lanes: lane LANES-1 is most significant, down to lane LANES-N.
  - Product P = A * b, width (N+1)*MIN_W, computed as a sum of lane products shifted by MIN_W per limb.
  - If N > LANES (illegal mode), P = 0. This is not an error.
- Stage 1 (edge accepting op): register P zero-extended/truncated to ACC_W as p1. Also register acc_en, start, init_val, and trunc1 = (any P bit at or above ACC_W is nonzero). Set v1=1. When en=1 and no op is accepted, v1=0.
- Stage 2 (next en edge with v1=1):
  - acc_en=0: c <= p1; accumulator unchanged.
  - acc_en=1, start=1: acc <= init_val + p1; c <= same sum.
  - acc_en=1, start=0: acc <= acc + p1; c <= same sum.
  - Sums wrap modulo 2**ACC_W.
  - out_valid <= 1. When v1=0 under en=1: out_valid <= 0 and c holds.
- Latency: exactly 2 enabled edges from acceptance to out_valid. Throughput 1 op per cycle. Back-to-back accumulation uses the stage-2 result directly, with no bubble.
- ovf:
  - Set on a stage-2 op with carry-out of the accumulate add, or with trunc1.
  - An op with start=1 (acc_en=1) clears ovf, then ORs in that op's own carry/trunc.
  - Multiply-only ops never clear it.
- Mixing ops: a multiply-only op between accumulate ops leaves acc intact. The following start=0 op continues from the last acc.

Decomposition:
- Shared include mac_const.vh gains the mode encodings MAC_MODE_X1=0, X2=1, X4=2, X8=3, X16=4, plus the default MIN_W/ACC_W macros.
- One sub-module: mac_wide_mult, combinational (MIN_W, LANES, MODE_W) -> P. It generates LANES lane multipliers and a masked shifted adder tree.
- Pipeline regs, accumulator and flag logic live in mac_block_param.

Test Plan:
- MIN_W=8, LANES=4, ACC_W=48, en=1 throughout, mode=0, acc_en=0, lane3=0x12, b=0x10 -> out_valid pulses exactly 2 cycles later, c=0x120, ovf=0.
- mode=2, a=0x01020304, b=0x02; mode=1 with same a, b=0x03 on the next cycle -> c=0x02040608, then c=0x0306 (lanes 3:2 = 0x0102 * 3) on consecutive cycles.
- acc_en=1: start=1/init=100 with 5*3, then start=0 with 2*7, then start=0 acc_en=0 with 1*1, then start=0 acc_en=1 with 1*1 -> c = 115, 129, 1, 130.
- Streaming accumulate with en dropped low 3 cycles mid-stream -> out_valid/c frozen during the stall; final sum equals the no-stall run and no op is lost or duplicated.
- start=1, init=0xFFFF_FFFF_FFFF, product 1*1 -> c=0, ovf=1. Next op start=1, init=0, product 2*2 -> c=4, ovf=0.
- rst pulsed asynchronously between clk edges with 2 ops in flight -> out_valid, c and ovf go 0 immediately. No result emerges for those ops. The next op after release returns at 2-cycle latency.
